compress_ctrl: RTL and testbench

COMPRESS_CTRL -- requirements
Module: compress_ctrl

---
 rtl/compress_defines_pkg.sv | 33 +++
 rtl/compress_ctrl_packer.sv | 55 +++++
 rtl/compress_unit.sv | 32 +++
 rtl/compress_ctrl.sv | 171 +++++++++++++++++
 tb/tb_compress_ctrl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/compress_defines_pkg.sv
// Shared types and constants for the coefficient compression controller.
package compress_defines_pkg;

   typedef enum logic [1:0] {
      MODE_D1   = 2'd0,
      MODE_D5   = 2'd1,
      MODE_D11  = 2'd2,
      MODE_PASS = 2'd3
   } compress_mode_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } ctrl_state_t;

   localparam int COMPRESS_CTRL_BUF_W   = 80;
   localparam int COMPRESS_CTRL_OUT_W   = 32;
   localparam int COMPRESS_CTRL_Q       = 3329;
   localparam int COMPRESS_CTRL_N_READS = 64;

   // Bits kept per coefficient for each mode; pass-through keeps all 12.
   function automatic logic [3:0] mode_to_d(input compress_mode_t m);
      case (m)
         MODE_D1:  return 4'd1;
         MODE_D5:  return 4'd5;
         MODE_D11: return 4'd11;
         default:  return 4'd12;
      endcase
   endfunction

endpackage

// File: rtl/compress_ctrl_packer.sv
// compress_packer: 80-bit LSB-first packing buffer with fill counter.
// Appends a chunk of chunk_bits_i bits above the current fill and pops
// 32-bit words from the bottom; push and pop may happen in the same cycle.
module compress_packer
   import compress_defines_pkg::*;
(
   input  logic        clk,
   input  logic        rst_b,
   input  logic        clr_i,
   input  logic        push_i,
   input  logic [47:0] chunk_i,
   input  logic [6:0]  chunk_bits_i,
   input  logic        ready_i,
   output logic [31:0] data_o,
   output logic        valid_o,
   output logic [6:0]  fill_o
);

   logic [COMPRESS_CTRL_BUF_W-1:0] pack_q, pack_d;
   logic [COMPRESS_CTRL_BUF_W-1:0] shifted;
   logic [6:0]                     fill_q, fill_d, fill_s;
   logic                           pop;

   // Pop first, then place the new chunk directly above what remains.
   always_comb begin
      valid_o = (fill_q >= 7'(COMPRESS_CTRL_OUT_W));
      pop     = valid_o & ready_i;
      shifted = pop ? (pack_q >> COMPRESS_CTRL_OUT_W) : pack_q;
      fill_s  = pop ? (fill_q - 7'(COMPRESS_CTRL_OUT_W)) : fill_q;
      pack_d  = shifted;
      fill_d  = fill_s;
      if (push_i) begin
         pack_d = shifted | ({{(COMPRESS_CTRL_BUF_W-48){1'b0}}, chunk_i} << fill_s);
         fill_d = fill_s + chunk_bits_i;
      end
      if (clr_i) begin
         pack_d = '0;
         fill_d = '0;
      end
      data_o = pack_q[COMPRESS_CTRL_OUT_W-1:0];
      fill_o = fill_q;
   end

   // Buffer and fill registers.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         pack_q <= '0;
         fill_q <= '0;
      end else begin
         pack_q <= pack_d;
         fill_q <= fill_d;
      end
   end

endmodule

// File: rtl/compress_unit.sv
// One lane compressor: round(x * 2^d / q) mod 2^d, or x unchanged in pass-through.
module compress_unit
   import compress_defines_pkg::*;
(
   input  compress_mode_t mode_i,
   input  logic [11:0]    coef_i,
   output logic [11:0]    res_o
);

   // q is odd, so floor((a + (q-1)/2) / q) never hits a tie and equals round(a / q).
   function automatic logic [11:0] round_div_q(input logic [23:0] num);
      logic [24:0] quo;
      quo = ({1'b0, num} + 25'd1664) / 25'(COMPRESS_CTRL_Q);
      return 12'(quo);
   endfunction

   logic [3:0]  d;
   logic [23:0] scaled;
   logic [11:0] q_val;
   logic [11:0] mask;

   // Scale, round-divide by q and keep the low d bits.
   always_comb begin
      d      = mode_to_d(mode_i);
      scaled = {12'd0, coef_i} << d;
      q_val  = round_div_q(scaled);
      mask   = (12'd1 << d) - 12'd1;
      if (mode_i == MODE_PASS) res_o = coef_i;
      else                     res_o = q_val & mask;
   end

endmodule

// File: rtl/compress_ctrl.sv
// compress_ctrl: reads 64 x 4 coefficients, compresses them to d bits each
// and streams the packed bits as 32-bit words.
// Optional build macro COMPRESS_CTRL_RANGE_CHK_EN adds a sticky err_o for
// any input coefficient >= q; without it err_o is tied low.
module compress_ctrl
   import compress_defines_pkg::*;
#(
   parameter int ADDR_WIDTH = 15
) (
   input  logic                  clk,
   input  logic                  rst_b,
   input  logic                  zeroize,
   input  logic                  start_i,
   input  compress_mode_t        mode_i,
   input  logic [ADDR_WIDTH-1:0] src_base_i,
   output logic                  mem_rd_en_o,
   output logic [ADDR_WIDTH-1:0] mem_rd_addr_o,
   input  logic [47:0]           mem_rd_data_i,
   output logic [31:0]           data_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o
);

   ctrl_state_t           state_q, state_d;
   compress_mode_t        mode_q, mode_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [6:0]            rd_cnt_q, rd_cnt_d;
   logic                  rd_pend_q, rd_pend_d;

   logic [3:0]  d;
   logic [6:0]  chunk_bits;
   logic [5:0]  sh1, sh2, sh3;
   logic [47:0] chunk;
   logic [11:0] lane_res [4];
   logic [6:0]  fill;
   logic        room_ok;
   logic        rd_en;

   assign d          = mode_to_d(mode_q);
   assign chunk_bits = {1'b0, d, 2'b00};

   for (genvar l = 0; l < 4; l++) begin : g_lane
      compress_unit u_cu (
         .mode_i (mode_q),
         .coef_i (mem_rd_data_i[12*l +: 12]),
         .res_o  (lane_res[l])
      );
   end

   // Concatenate the four d-bit results, lane 0 in the lowest bits.
   always_comb begin
      sh1   = {2'b00, d};
      sh2   = {1'b0, d, 1'b0};
      sh3   = sh1 + sh2;
      chunk = 48'(lane_res[0]) | (48'(lane_res[1]) << sh1)
            | (48'(lane_res[2]) << sh2) | (48'(lane_res[3]) << sh3);
   end

   compress_packer u_packer (
      .clk          (clk),
      .rst_b        (rst_b),
      .clr_i        (zeroize),
      .push_i       (rd_pend_q),
      .chunk_i      (chunk),
      .chunk_bits_i (chunk_bits),
      .ready_i      (ready_i),
      .data_o       (data_o),
      .valid_o      (valid_o),
      .fill_o       (fill)
   );

   // A read may go out only if the buffer can absorb it plus the one already returning.
   always_comb begin
      room_ok = (8'(fill) + (rd_pend_q ? 8'(chunk_bits) : 8'd0) + 8'(chunk_bits))
                <= 8'(COMPRESS_CTRL_BUF_W);
      rd_en   = (state_q == ST_READ) && (rd_cnt_q < 7'(COMPRESS_CTRL_N_READS))
                && room_ok && !zeroize;
      mem_rd_en_o   = rd_en;
      mem_rd_addr_o = base_q + ADDR_WIDTH'(rd_cnt_q);
   end

   // Next-state and control outputs.
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      base_d    = base_q;
      rd_cnt_d  = rd_cnt_q;
      rd_pend_d = rd_en;
      busy_o    = 1'b0;
      done_o    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d  = ST_READ;
               mode_d   = mode_i;
               base_d   = src_base_i;
               rd_cnt_d = '0;
            end
         end
         ST_READ: begin
            busy_o = 1'b1;
            if (rd_en) rd_cnt_d = rd_cnt_q + 7'd1;
            // Last read issued and its data already pushed into the packer.
            if ((rd_cnt_q == 7'(COMPRESS_CTRL_N_READS)) && !rd_pend_q) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            busy_o = 1'b1;
            if (fill == 7'd0) state_d = ST_DONE;
         end
         default: begin
            done_o  = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
      if (zeroize) begin
         state_d   = ST_IDLE;
         mode_d    = MODE_D1;
         base_d    = '0;
         rd_cnt_d  = '0;
         rd_pend_d = 1'b0;
         done_o    = 1'b0;
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q   <= ST_IDLE;
         mode_q    <= MODE_D1;
         base_q    <= '0;
         rd_cnt_q  <= '0;
         rd_pend_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         base_q    <= base_d;
         rd_cnt_q  <= rd_cnt_d;
         rd_pend_q <= rd_pend_d;
      end
   end

`ifdef COMPRESS_CTRL_RANGE_CHK_EN
   logic err_q, err_d;
   logic range_bad;

   // Sticky flag for out-of-range coefficients; a new accepted start clears it.
   always_comb begin
      range_bad = 1'b0;
      for (int l = 0; l < 4; l++) begin
         if (mem_rd_data_i[12*l +: 12] >= 12'(COMPRESS_CTRL_Q)) range_bad = 1'b1;
      end
      err_d = err_q;
      if ((state_q == ST_IDLE) && start_i) err_d = 1'b0;
      if (rd_pend_q && range_bad)          err_d = 1'b1;
      if (zeroize)                         err_d = 1'b0;
      err_o = err_q;
   end

   // Error flag register.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) err_q <= 1'b0;
      else        err_q <= err_d;
   end
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_compress_ctrl.sv
// Directed self-checking bench for compress_ctrl.
module tb_compress_ctrl;
   import compress_defines_pkg::*;

   localparam int AW = 15;
`ifdef COMPRESS_CTRL_RANGE_CHK_EN
   localparam int EXP_ERR = 1;
`else
   localparam int EXP_ERR = 0;
`endif

   logic           clk = 1'b0;
   logic           rst_b, zeroize, start_i;
   logic           ready_i = 1'b1;
   compress_mode_t mode_i;
   logic [AW-1:0]  src_base_i, mem_rd_addr_o;
   logic           mem_rd_en_o;
   logic [47:0]    mem_rd_data_i = '0;
   logic [31:0]    data_o;
   logic           valid_o, busy_o, done_o, err_o;

   int          checks = 0, failures = 0;
   int          word_cnt = 0, word_base = 0, done_cnt = 0, done_base = 0;
   int          rd_cnt = 0, rd_base = 0, exp_n = 0, ready_mode = 0;
   logic [31:0] exp_w [96];
   int          coef [256];
   logic [47:0] mem [64];
   logic [AW-1:0] cur_base = '0;
   logic        stall_prev = 1'b0;
   logic [31:0] held = '0;

   compress_ctrl #(.ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst_b(rst_b), .zeroize(zeroize), .start_i(start_i),
      .mode_i(mode_i), .src_base_i(src_base_i), .mem_rd_en_o(mem_rd_en_o),
      .mem_rd_addr_o(mem_rd_addr_o), .mem_rd_data_i(mem_rd_data_i),
      .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Source memory: data one cycle after the read strobe.
   always @(posedge clk) begin
      if (mem_rd_en_o) begin
         logic [AW-1:0] a;
         a = mem_rd_addr_o - cur_base;
         #1 mem_rd_data_i = mem[a[5:0]];
      end
   end

   // Downstream ready pattern.
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       ready_i = 1'b1;
         1:       ready_i = 1'($urandom_range(0, 1));
         default: ready_i = 1'b0;
      endcase
   end

   // Output / read monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_b) begin
         if (mem_rd_en_o) begin
            chk("rd_addr", 32'(mem_rd_addr_o), 32'(cur_base + AW'(rd_cnt - rd_base)));
            rd_cnt++;
         end
         if (stall_prev) begin
            chk("stall_valid", 32'(valid_o), 1);
            chk("stall_data", data_o, held);
         end
         if (valid_o && ready_i) begin
            if (word_cnt - word_base < exp_n) chk("word", data_o, exp_w[word_cnt - word_base]);
            else                              chk("extra_word", word_cnt - word_base, exp_n);
            word_cnt++;
         end
         stall_prev = valid_o && !ready_i && !zeroize;
         held       = data_o;
         if (done_o) done_cnt++;
      end
   end

   function automatic int ref_compress(input int x, input int m);
      int dd, num;
      if (m == 3) return x;
      dd  = (m == 0) ? 1 : (m == 1) ? 5 : 11;
      num = x * (1 << dd);
      return ((2 * num + 3329) / (2 * 3329)) % (1 << dd);
   endfunction

   task automatic load_mem();
      for (int j = 0; j < 64; j++)
         mem[j] = {12'(coef[4*j+3]), 12'(coef[4*j+2]), 12'(coef[4*j+1]), 12'(coef[4*j])};
   endtask

   task automatic build_expected(input int m);
      logic [3071:0] stream;
      int dd, r;
      dd = (m == 0) ? 1 : (m == 1) ? 5 : (m == 2) ? 11 : 12;
      stream = '0;
      for (int i = 0; i < 256; i++) begin
         r = ref_compress(coef[i], m);
         for (int b = 0; b < dd; b++) stream[i*dd + b] = r[b];
      end
      exp_n = 256 * dd / 32;
      for (int k = 0; k < exp_n; k++) exp_w[k] = stream[k*32 +: 32];
   endtask

   task automatic pulse_start(input int m, input logic [AW-1:0] base);
      word_base  = word_cnt;
      done_base  = done_cnt;
      rd_base    = rd_cnt;
      cur_base   = base;
      mode_i     = compress_mode_t'(m[1:0]);
      src_base_i = base;
      start_i    = 1'b1;
      tick();
      start_i    = 1'b0;
   endtask

   task automatic wait_done(input int budget, input int n_words);
      int n;
      n = 0;
      while (done_cnt == done_base && n < budget) begin
         tick();
         n++;
      end
      repeat (4) tick();
      chk("word_count", word_cnt - word_base, n_words);
      chk("done_pulses", done_cnt - done_base, 1);
      chk("read_count", rd_cnt - rd_base, 64);
      chk("idle_busy", 32'(busy_o), 0);
   endtask

   initial begin
      rst_b = 1'b0; zeroize = 1'b0; start_i = 1'b0;
      mode_i = MODE_D1; src_base_i = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 32'(valid_o), 0);
      chk("rst_busy", 32'(busy_o), 0);
      chk("rst_done", 32'(done_o), 0);
      chk("rst_rd_en", 32'(mem_rd_en_o), 0);
      chk("rst_data", data_o, 0);
      chk("rst_err", 32'(err_o), 0);
      @(posedge clk);
      #1 rst_b = 1'b1;
      tick();

      // Mode 0, all 1665 -> every bit is 1.
      for (int i = 0; i < 256; i++) coef[i] = 1665;
      load_mem();
      exp_n = 8;
      for (int k = 0; k < 8; k++) exp_w[k] = 32'hFFFF_FFFF;
      ready_mode = 0;
      pulse_start(0, 15'h0100);
      wait_done(3000, 8);
      chk("t1_err", 32'(err_o), 0);

      // Mode 1, ramp data, random ready; a start while busy must be ignored.
      for (int i = 0; i < 256; i++) coef[i] = i * 13;
      load_mem();
      build_expected(1);
      ready_mode = 1;
      pulse_start(1, 15'h1234);
      repeat (20) tick();
      chk("t2_busy", 32'(busy_o), 1);
      mode_i = MODE_PASS; src_base_i = 15'h0000; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      wait_done(3000, 40);

      // Mode 3 with the sink stalled: exactly one read fits, first word held.
      for (int i = 0; i < 256; i++) coef[i] = (i * 97) % 3329;
      load_mem();
      build_expected(3);
      ready_mode = 2;
      tick();
      pulse_start(3, 15'h7FC0);
      repeat (100) tick();
      chk("t3_reads", rd_cnt - rd_base, 1);
      chk("t3_valid", 32'(valid_o), 1);
      chk("t3_data", data_o, exp_w[0]);
      chk("t3_busy", 32'(busy_o), 1);
      ready_mode = 1;
      wait_done(3000, 96);

      // Mode 2, zeroize mid-read, then a clean rerun.
      for (int i = 0; i < 256; i++) coef[i] = (i * 1000 + 7) % 3329;
      load_mem();
      build_expected(2);
      ready_mode = 0;
      pulse_start(2, 15'h0040);
      repeat (30) tick();
      chk("t4_busy", 32'(busy_o), 1);
      zeroize = 1'b1;
      tick();
      zeroize = 1'b0;
      chk("t4_zero_busy", 32'(busy_o), 0);
      chk("t4_zero_valid", 32'(valid_o), 0);
      chk("t4_zero_rd_en", 32'(mem_rd_en_o), 0);
      chk("t4_zero_err", 32'(err_o), 0);
      repeat (20) tick();
      chk("t4_no_done", done_cnt - done_base, 0);
      pulse_start(2, 15'h0040);
      wait_done(3000, 88);

      // Out-of-range coefficient in pass-through mode.
      for (int i = 0; i < 256; i++) coef[i] = i;
      coef[77] = 4095;
      load_mem();
      build_expected(3);
      pulse_start(3, 15'h0200);
      wait_done(3000, 96);
      chk("t5_err", 32'(err_o), EXP_ERR);
      repeat (5) tick();
      chk("t5_err_sticky", 32'(err_o), EXP_ERR);
      for (int i = 0; i < 256; i++) coef[i] = 1665;
      load_mem();
      exp_n = 8;
      for (int k = 0; k < 8; k++) exp_w[k] = 32'hFFFF_FFFF;
      pulse_start(0, 15'h0300);
      chk("t5_err_clr", 32'(err_o), 0);
      wait_done(3000, 8);
      chk("t5_err_after", 32'(err_o), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
